// File: rtl/fw_stream_feeder_pkg.sv
// Shared types and constants for the Floyd-Warshall matrix feeder.
package fw_stream_feeder_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StReady,
    StStream
  } state_e;

  localparam logic [1:0] PH_FIRST = 2'b01;
  localparam logic [1:0] PH_NEXT  = 2'b10;
  localparam logic [1:0] PH_IDLE  = 2'b00;

endpackage

// File: rtl/fw_feed_ram.sv
// Simple dual-port matrix buffer: one write port, one synchronous read port, no reset.
module fw_feed_ram #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fw_stream_feeder.sv
// Buffers one N x N distance matrix and replays it into the fw core for a
// programmable number of passes, honouring the core's inhibit back-pressure.
module fw_stream_feeder
  import fw_stream_feeder_pkg::*;
#(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned N      = 8,
  parameter int unsigned PASS_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ELEM_W*LANES-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    clear,
  input  logic                    start,
  input  logic [PASS_W-1:0]       passes,
  input  logic                    zinf,
  input  logic                    inhibit,
  output logic [ELEM_W*LANES-1:0] outD,
  output logic                    out_valid,
  output logic [1:0]              phase,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WORD_W = ELEM_W * LANES;
  localparam int unsigned DEPTH  = N * N / LANES;
  localparam int unsigned WPR    = N / LANES;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if (N % LANES != 0) begin : g_bad_n
    $error("fw_stream_feeder: N must be a multiple of LANES");
  end

  state_e state_q, state_d;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_idx_q;
  logic [PASS_W-1:0] pass_q, npass_q;
  logic              zinf_q, issue_done_q;
  logic              rd_vld_q, rd_first_q, rd_last_q;
  logic              skid_vld_q, skid_first_q, skid_last_q;
  logic [WORD_W-1:0] skid_data_q, out_data_q;
  logic              out_valid_q, out_last_q, done_q;
  logic [1:0]        phase_q;

  logic              accept, consume, out_adv, issue, last_issue, start_go;
  logic [WORD_W-1:0] ram_rdata, sub_data, src_data;
  logic              src_vld, src_first, src_last;

  assign accept     = (state_q == StLoad) && load_valid && !clear;
  assign start_go   = (state_q == StReady) && start && !clear;
  assign consume    = out_valid_q && !inhibit;
  assign out_adv    = !out_valid_q || !inhibit;
  // Only issue a read when its data is guaranteed a landing slot next cycle.
  assign issue      = (state_q == StStream) && !clear && !issue_done_q && out_adv && !skid_vld_q;
  assign last_issue = (rd_ptr_q == LAST_ADDR) && (pass_q == npass_q - 1'b1);

  fw_feed_ram #(
    .Width(WORD_W),
    .Depth(DEPTH),
    .Aw   (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(load_data),
    .re_i   (issue),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  // Off-diagonal zero means "no edge"; map it to the saturated distance.
  always_comb begin
    sub_data = ram_rdata;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (zinf_q && (ram_rdata[l*ELEM_W +: ELEM_W] == '0) &&
          ((32'(rd_idx_q) / WPR) != ((32'(rd_idx_q) % WPR) * LANES + l))) begin
        sub_data[l*ELEM_W +: ELEM_W] = '1;
      end
    end
  end

  always_comb begin
    src_vld   = skid_vld_q || rd_vld_q;
    src_data  = skid_vld_q ? skid_data_q  : sub_data;
    src_first = skid_vld_q ? skid_first_q : rd_first_q;
    src_last  = skid_vld_q ? skid_last_q  : rd_last_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: begin
        if (accept && (wr_ptr_q == LAST_ADDR)) state_d = StReady;
      end
      StReady: begin
        if (clear)      state_d = StLoad;
        else if (start) state_d = StStream;
      end
      StStream: begin
        if (clear)                        state_d = StLoad;
        else if (consume && out_last_q)   state_d = StReady;
      end
      default: state_d = StLoad;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_ready = (state_q == StLoad);
    busy       = (state_q == StStream);
    outD       = out_data_q;
    out_valid  = out_valid_q;
    phase      = phase_q;
    done       = done_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
    end else if (accept) begin
      wr_ptr_q <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      rd_idx_q     <= '0;
      pass_q       <= '0;
      npass_q      <= '0;
      zinf_q       <= 1'b0;
      issue_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_first_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      phase_q      <= PH_IDLE;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        rd_vld_q    <= 1'b0;
        skid_vld_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        phase_q     <= PH_IDLE;
      end else if (start_go) begin
        rd_ptr_q     <= '0;
        pass_q       <= '0;
        npass_q      <= (passes == '0) ? PASS_W'(1) : passes;
        zinf_q       <= zinf;
        issue_done_q <= 1'b0;
        phase_q      <= PH_FIRST;
      end else if (state_q == StStream) begin
        rd_vld_q <= issue;
        if (issue) begin
          rd_idx_q   <= rd_ptr_q;
          rd_first_q <= (pass_q == '0);
          rd_last_q  <= last_issue;
          if (last_issue) issue_done_q <= 1'b1;
          if (rd_ptr_q == LAST_ADDR) begin
            rd_ptr_q <= '0;
            pass_q   <= pass_q + 1'b1;
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        if (out_adv) begin
          out_valid_q <= src_vld;
          skid_vld_q  <= 1'b0;
          if (src_vld) begin
            out_data_q <= src_data;
            out_last_q <= src_last;
            phase_q    <= src_first ? PH_FIRST : PH_NEXT;
          end
        end else if (rd_vld_q) begin
          skid_vld_q   <= 1'b1;
          skid_data_q  <= sub_data;
          skid_first_q <= rd_first_q;
          skid_last_q  <= rd_last_q;
        end
        if (consume && out_last_q) begin
          done_q  <= 1'b1;
          phase_q <= PH_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fw_stream_feeder.sv
// Scoreboard bench for fw_stream_feeder with N=8, LANES=4 (16 words of 64 bits).
module tb_fw_stream_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] load_data;
  logic        load_valid, load_ready, clear, start, zinf, inhibit;
  logic [3:0]  passes;
  logic [63:0] outD;
  logic        out_valid, busy, done;
  logic [1:0]  phase;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  ph;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model[16];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          words = 0;
  bit          mon_en = 1'b0;
  bit          stall_q = 1'b0;
  logic [63:0] held_data;
  logic [1:0]  held_ph;

  fw_stream_feeder #(
    .ELEM_W(16),
    .LANES (4),
    .N     (8),
    .PASS_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .clear     (clear),
    .start     (start),
    .passes    (passes),
    .zinf      (zinf),
    .inhibit   (inhibit),
    .outD      (outD),
    .out_valid (out_valid),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model_word(input int w, input bit zi);
    logic [63:0] v;
    v = model[w];
    for (int l = 0; l < 4; l++) begin
      if (zi && (v[16*l +: 16] == 16'h0) && ((w / 2) != ((w % 2) * 4 + l))) v[16*l +: 16] = 16'hffff;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      load_data  = model[base + k];
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_load_ready", 64'(load_ready), 64'd1);
  endtask

  task automatic run_stream(input int np, input bit zi, input bit tog, input int nw);
    int cyc, first, dseen;
    for (int p = 0; p < np; p++)
      for (int w = 0; w < 16; w++)
        exp_q.push_back('{data: model_word(w, zi), ph: (p == 0) ? 2'b01 : 2'b10});
    done_cnt = 0;
    words    = 0;
    passes   = 4'(np);
    zinf     = zi;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    cyc = 0; first = -1; dseen = -1;
    while (cyc < 400 && dseen < 0) begin
      if (tog) inhibit = ~inhibit;
      tick();
      cyc++;
      if (out_valid && first < 0) first = cyc;
      if (done) dseen = cyc;
    end
    inhibit = 1'b0;
    check("done_seen", 64'(dseen >= 0), 64'd1);
    if (!tog) begin
      check("first_latency", 64'(first), 64'd2);
      check("no_bubbles", 64'(dseen - first), 64'(nw));
    end
    repeat (3) tick();
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("word_count", 64'(words), 64'(nw));
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("idle_phase", 64'(phase), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("sb_empty_at_done", 64'(exp_q.size()), 64'd0);
      end
      if (stall_q) begin
        check("hold_data", outD, held_data);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_phase", 64'(phase), 64'(held_ph));
      end
      stall_q = 1'b0;
      if (out_valid && inhibit) begin
        stall_q   = 1'b1;
        held_data = outD;
        held_ph   = phase;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("data", outD, e.data);
          check("phase", 64'(phase), 64'(e.ph));
          words++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0; load_data = '0; load_valid = 1'b0; clear = 1'b0;
    start = 1'b0; passes = '0; zinf = 1'b0; inhibit = 1'b0;
    repeat (2) tick();
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outD", outD, 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    for (int k = 0; k < 16; k++) model[k] = {4{16'(k)}};
    load_words(16, 0);
    check("ready_after_16", 64'(load_ready), 64'd0);
    run_stream(1, 1'b0, 1'b0, 16);
    run_stream(1, 1'b0, 1'b1, 16);
    run_stream(3, 1'b0, 1'b0, 48);

    do_clear();
    model[0] = 64'h0061_0047_003f_0000;
    model[2] = 64'h0045_0040_005d_0000;
    load_words(16, 0);
    run_stream(1, 1'b1, 1'b0, 16);

    // Start with a partially loaded buffer must be ignored.
    do_clear();
    for (int k = 0; k < 16; k++) model[k] = {4{16'(k)}};
    load_words(10, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid || busy) found = 1'b1;
    end
    check("early_start_ignored", 64'(found), 64'd0);
    load_words(6, 10);
    load_data  = 64'hdead_beef_dead_beef;
    load_valid = 1'b1;
    check("no_17th_ready", 64'(load_ready), 64'd0);
    tick();
    load_valid = 1'b0;
    run_stream(1, 1'b0, 1'b0, 16);

    // Asynchronous reset mid-stream.
    for (int w = 0; w < 16; w++) exp_q.push_back('{data: model[w], ph: 2'b01});
    passes = 4'd1;
    zinf   = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (out_valid && outD == model[5]) found = 1'b1;
    end
    check("reach_word5", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_phase", 64'(phase), 64'd0);
    exp_q.delete();
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_load_ready", 64'(load_ready), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid || busy) found = 1'b1;
    end
    check("start_without_reload", 64'(found), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
